// File: rtl/mem_cycle_ctl.sv
// CPU-side initiator for the 32k x 12 core memory: issues mem_start, captures the
// strobed read word, supplies restore/replace data and reports completion or timeout.
module mem_cycle_ctl #(
  parameter logic [8:0]  TIMEOUT = 9'd300,
  parameter int unsigned GAP     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [14:0] addr,
  input  logic [11:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic [11:0] rdata,
  output logic        zero,
  output logic        err,
  output logic        mem_start,
  output logic [14:0] mem_addr,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_data_in,
  input  logic        strobe_n,
  input  logic        mem_done_n
);

  localparam int unsigned   GW       = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

  typedef enum logic [1:0] {IDLE, WAIT_STB, WAIT_DONE} state_e;

  state_e        state_q, state_d;
  logic [8:0]    timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d, gap_dec;
  logic          strobe_q;
  logic [1:0]    op_q, op_d;
  logic [11:0]   wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          ack_q, ack_d;
  logic [11:0]   rdata_q, rdata_d;
  logic          zero_q, zero_d;
  logic          err_q, err_d;
  logic          mem_start_q, mem_start_d;
  logic [14:0]   mem_addr_q, mem_addr_d;
  logic [11:0]   mem_wdata_q, mem_wdata_d;

  logic accept, strobe_fall, timeout;

  // Accept on the edge where the gap count reaches zero, so mem_start stays
  // low for exactly GAP cycles between back-to-back requests.
  assign gap_dec     = (gap_q != '0) ? gap_q - GW'(1) : '0;
  assign accept      = (state_q == IDLE) && req && (gap_dec == '0);
  assign strobe_fall = strobe_q && !strobe_n;
  assign timeout     = (timer_q == TIMEOUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept) state_d = WAIT_STB;
      WAIT_STB:  if (timeout) state_d = IDLE;
                 else if (strobe_fall) state_d = WAIT_DONE;
      WAIT_DONE: if (timeout || !mem_done_n) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    timer_d     = timer_q;
    gap_d       = gap_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    zero_d      = zero_q;
    err_d       = err_q;
    mem_start_d = mem_start_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        gap_d = gap_dec;
        if (accept) begin
          mem_addr_d  = addr;
          op_d        = op;
          wdata_d     = wdata;
          err_d       = 1'b0;
          zero_d      = 1'b0;
          mem_start_d = 1'b1;
          busy_d      = 1'b1;
          timer_d     = '0;
        end
      end
      WAIT_STB, WAIT_DONE: begin
        timer_d = timer_q + 9'd1;
        if (timeout) begin
          err_d       = 1'b1;
          ack_d       = 1'b1;
          mem_start_d = 1'b0;
          busy_d      = 1'b0;
          gap_d       = GAP_LOAD;
        end else if (state_q == WAIT_STB) begin
          if (strobe_fall) begin
            rdata_d = mem_data_in;
            unique case (op_q)
              2'b01: mem_wdata_d = wdata_q;
              2'b10: begin
                mem_wdata_d = mem_data_in + 12'd1;
                zero_d      = (mem_data_in == 12'o7777);
              end
              default: mem_wdata_d = mem_data_in;
            endcase
          end
        end else if (!mem_done_n) begin
          ack_d       = 1'b1;
          mem_start_d = 1'b0;
          busy_d      = 1'b0;
          gap_d       = GAP_LOAD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q     <= '0;
      gap_q       <= '0;
      strobe_q    <= 1'b1;
      op_q        <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_start_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      timer_q     <= timer_d;
      gap_q       <= gap_d;
      strobe_q    <= strobe_n;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      mem_start_q <= mem_start_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign mem_start = mem_start_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_cycle_ctl.sv
// Directed bench for mem_cycle_ctl with a behavioural core-memory stub
// (strobe at memory timer 50, write at 80, done at 149).
module tb_mem_cycle_ctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic [1:0]  op;
  logic [14:0] addr;
  logic [11:0] wdata;
  logic        busy, ack, zero, err, mem_start;
  logic [11:0] rdata, mem_wdata;
  logic [14:0] mem_addr;
  logic [11:0] mdata = '0;
  logic        strobe_n = 1'b1;
  logic        mem_done_n = 1'b1;

  logic [11:0] mem [0:32767];
  logic [8:0]  mt = '0;
  logic        start_prev = 1'b0;
  logic        no_done = 1'b0;
  logic        spur = 1'b0;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  mem_cycle_ctl #(.TIMEOUT(9'd300), .GAP(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .ack(ack), .rdata(rdata), .zero(zero), .err(err),
    .mem_start(mem_start), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_in(mdata), .strobe_n(strobe_n), .mem_done_n(mem_done_n)
  );

  // Core memory stub: restarts on a mem_start rising edge seen at a clock edge.
  always @(posedge clk) begin
    start_prev <= mem_start;
    if (mem_start && !start_prev) begin
      mt         <= 9'd1;
      mem_done_n <= 1'b1;
      strobe_n   <= 1'b1;
    end else if (mt != 9'd0) begin
      if (mt < 9'd400) mt <= mt + 9'd1;
      if (mt == 9'd49) begin strobe_n <= 1'b0; mdata <= mem[mem_addr]; end
      if (mt == 9'd59) strobe_n <= 1'b1;
      if (mt == 9'd79) mem[mem_addr] <= mem_wdata;
      if (spur && mt == 9'd99) begin strobe_n <= 1'b0; mdata <= 12'o4444; end
      if (spur && mt == 9'd103) strobe_n <= 1'b1;
      if (!no_done && mt == 9'd148) mem_done_n <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [14:0] a, input logic [11:0] v);
    mem[a] <= v;
  endtask

  // Issue one request after an idle gap; n returns cycles from accept edge to ack.
  task automatic run(input logic [1:0] o, input logic [14:0] a, input logic [11:0] w,
                     output int n);
    repeat (3) @(negedge clk);
    op = o; addr = a; wdata = w; req = 1'b1;
    @(posedge clk); #1;
    check("accept_busy", busy, 1);
    check("accept_start", mem_start, 1);
    check("accept_err_clr", err, 0);
    req = 1'b0;
    n = 0;
    while (n < 400) begin
      @(posedge clk); #1;
      n++;
      if (ack) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, low;
    reset_n = 1'b0; req = 1'b0; op = '0; addr = '0; wdata = '0;
    poke(15'o01234, 12'o5252);
    poke(15'o70000, 12'o1111);
    poke(15'o00010, 12'o7777);
    poke(15'o00011, 12'o0005);
    poke(15'o00020, 12'o1357);
    poke(15'o00030, 12'o2222);
    poke(15'o00040, 12'o0123);
    poke(15'o00041, 12'o0456);
    poke(15'o00050, 12'o0765);
    poke(15'o00060, 12'o0111);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_start", mem_start, 0);
    check("rst_rdata", rdata, 0);
    check("rst_maddr", mem_addr, 0);
    reset_n = 1'b1;

    // READ restore
    run(2'b00, 15'o01234, 12'o0000, n);
    check("read_lat", n, 150);
    check("read_rdata", rdata, 12'o5252);
    check("read_start_low", mem_start, 0);
    check("read_busy_low", busy, 0);
    check("read_maddr", mem_addr, 15'o01234);
    check("read_mem", mem[15'o01234], 12'o5252);
    @(posedge clk); #1;
    check("ack_one_cycle", ack, 0);

    // WRITE replace
    run(2'b01, 15'o70000, 12'o0707, n);
    check("write_lat", n, 150);
    check("write_rdata", rdata, 12'o1111);
    check("write_mem", mem[15'o70000], 12'o0707);
    check("write_zero", zero, 0);

    // INCR wrap, then plain INCR
    run(2'b10, 15'o00010, 12'o0000, n);
    check("incw_rdata", rdata, 12'o7777);
    check("incw_mem", mem[15'o00010], 12'o0000);
    check("incw_zero", zero, 1);
    run(2'b10, 15'o00011, 12'o0000, n);
    check("inc_rdata", rdata, 12'o0005);
    check("inc_mem", mem[15'o00011], 12'o0006);
    check("inc_zero", zero, 0);

    // op 11 behaves as READ
    run(2'b11, 15'o00020, 12'o7070, n);
    check("op3_rdata", rdata, 12'o1357);
    check("op3_mem", mem[15'o00020], 12'o1357);

    // Spurious strobe during WAIT_DONE must not recapture
    spur = 1'b1;
    run(2'b01, 15'o00030, 12'o3333, n);
    spur = 1'b0;
    check("spur_lat", n, 150);
    check("spur_rdata", rdata, 12'o2222);
    check("spur_wdata", mem_wdata, 12'o3333);
    check("spur_mem", mem[15'o00030], 12'o3333);

    // Back-to-back with req held high
    repeat (3) @(negedge clk);
    op = 2'b00; addr = 15'o00040; wdata = '0; req = 1'b1;
    @(posedge clk); #1;
    check("b2b_accept1", busy, 1);
    op = 2'b10; addr = 15'o00041;
    n = 0;
    while (n < 400) begin
      @(posedge clk); #1;
      n++;
      if (ack) break;
    end
    check("b2b_lat1", n, 150);
    check("b2b_rdata1", rdata, 12'o0123);
    low = 0;
    while (low < 10) begin
      if (mem_start) break;
      low++;
      @(posedge clk); #1;
    end
    check("b2b_gap", low, 2);
    check("b2b_accept2", busy, 1);
    check("b2b_maddr2", mem_addr, 15'o00041);
    req = 1'b0;
    n = 0;
    while (n < 400) begin
      @(posedge clk); #1;
      n++;
      if (ack) break;
    end
    check("b2b_lat2", n, 150);
    check("b2b_rdata2", rdata, 12'o0456);
    check("b2b_mem2", mem[15'o00041], 12'o0457);

    // Timeout: memory never signals done
    no_done = 1'b1;
    run(2'b00, 15'o00050, 12'o0000, n);
    no_done = 1'b0;
    check("to_lat", n, 301);
    check("to_ack", ack, 1);
    check("to_err", err, 1);
    check("to_start_low", mem_start, 0);
    check("to_rdata", rdata, 12'o0765);
    run(2'b00, 15'o00050, 12'o0000, n);
    check("to_next_lat", n, 150);
    check("to_next_err", err, 0);

    // Reset in the middle of WAIT_DONE
    repeat (3) @(negedge clk);
    op = 2'b00; addr = 15'o00060; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_start", mem_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_wdata", mem_wdata, 0);
    check("mid_rst_maddr", mem_addr, 0);
    check("mid_rst_zero_err", {zero, err}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run(2'b00, 15'o00060, 12'o0000, n);
    check("post_rst_lat", n, 150);
    check("post_rst_rdata", rdata, 12'o0111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_cycle_ctl.md
Name: mem_cycle_ctl

Overview:
CPU-side initiator for the 32k x 12 core memory model. It accepts one memory request from the CPU timing logic and generates the mem_start handshake. It captures read data on the memory strobe and drives the restore or replace data for the write half of the cycle. It reports completion with a one-cycle ack, and raises err if the memory does not respond.

Parameters:
TIMEOUT, 9'd300, max cycles from mem_start rise to mem_done_n low before abort (nominal response ~150).
GAP, 2, min cycles mem_start held low between cycles (memory start is rising-edge detected).

Ports:
clk  in  1  100 MHz system clock
reset_n  in  1  asynchronous active-low reset
req  in  1  request; sampled only in IDLE
op  in  2  00 READ (restore), 01 WRITE (replace with wdata), 10 INCR (write read+1), 11 treated as READ
addr  in  15  field+address; latched at accept
wdata  in  12  write data for WRITE; latched at accept
busy  out  1  high from the accept edge until return to IDLE
ack  out  1  one-cycle completion pulse
rdata  out  12  word read from memory (pre-modify value)
zero  out  1  INCR result wrapped to 0 (ISZ skip); valid with ack, held until next accept
err  out  1  timeout occurred; valid with ack, held until next accept
mem_start  out  1  to memory mem_start
mem_addr  out  15  to memory addr; stable for the whole cycle
mem_wdata  out  12  to memory data_in
mem_data_in  in  12  from memory data_out
strobe_n  in  1  memory read strobe, active low
mem_done_n  in  1  memory done, active low

Behaviour:
- Clocking and reset: all outputs registered; single clock domain.
- Reset (async, reset_n=0) forces all outputs to 0, state to IDLE, timer and gap counter to 0, and strobe_q to 1. Reset mid-cycle drops mem_start immediately; the in-flight request is lost and no ack is issued.
- State IDLE:
  - busy=0.
  - If req=1 and gap counter=0, latch addr->mem_addr, op, wdata, and clear err, zero.
  - Set mem_start<=1, busy<=1, timer<=0; go to WAIT_STB.
  - If the gap counter is nonzero, req is ignored: no queuing, and the requester must hold req.
- State WAIT_STB:
  - Detect the strobe falling edge: strobe_q=1 and strobe_n=0, where strobe_q is strobe_n registered.
  - On that edge: rdata<=mem_data_in, and mem_wdata<= one of:
    - READ: mem_data_in.
    - WRITE: the latched wdata.
    - INCR: mem_data_in+1 mod 4096.
  - For INCR, zero<=(mem_data_in==12'o7777).
  - Go to WAIT_DONE.
  - mem_done_n is ignored here; it is still low from the previous cycle until the memory restarts.
- State WAIT_DONE: when mem_done_n=0 is sampled, set ack<=1 and mem_start<=0, load the gap counter with GAP, and go to IDLE.
- Timer:
  - Increments every cycle in WAIT_STB and WAIT_DONE.
  - When timer==TIMEOUT in either state: err<=1, ack<=1, mem_start<=0, load the gap counter, go to IDLE.
  - rdata is unchanged if the strobe was never seen.
- Gap counter: decrements to 0 while in IDLE. This guarantees mem_start stays low for at least GAP cycles, so the memory sees a fresh rising edge.
- Nominal timing (accept edge = edge 0):
  - mem_start high after edge 0.
  - Memory timer=1 at edge 1; strobe low after edge 50; capture at edge 51.
  - mem_wdata valid 29 cycles before the memory write window (timer 80).
  - mem_done_n low after edge 149; ack high after edge 150.
  - mem_start low after edge 150; next accept earliest at edge 152 with GAP=2.
- Stability during a cycle:
  - mem_addr does not change from accept until the next accept.
  - mem_wdata changes only at the strobe capture.
- Ack pulse: ack is high for exactly one cycle per accepted request.
- Boundary: a strobe falling edge in WAIT_DONE (spurious) is ignored, with no recapture.

Test Plan:
- Reset values: assert reset_n=0 mid-WAIT_DONE -> mem_start, busy, ack and all data outputs are 0 in the same cycle; after release, the next req starts a clean cycle.
- READ restore: preload mem[15'o01234]=12'o5252, req op=00 -> ack at edge 150; rdata=5252; memory still holds 5252.
- WRITE: mem[15'o70000]=12'o1111, op=01, wdata=12'o0707 -> rdata=1111, memory=0707, zero=0.
- INCR wrap: mem[15'o00010]=12'o7777, op=10 -> rdata=7777, memory=0000, zero=1. Then INCR on 0005 -> memory=0006, zero=0.
- Back-to-back: req held high -> second accept no earlier than 2 cycles after the first ack, with mem_start low for >=2 cycles. The second cycle's strobe capture does not use stale done_n.
- Timeout: memory stub never asserts mem_done_n -> ack with err=1 at timer==300; mem_start low; the next request clears err.
